prio_arb_tree: RTL and testbench

Registered N-input priority arbiter built as a balanced tree of 2:1 compare cells. Each requester presents a request bit and a priority value; the block selects the requesting input with the numerically smallest priority value (ties go to the lower index). It outputs the winner's index and priority plus an "any request" flag. It sits in front of shared-resource grant logic, and its outputs are registered once.

---
 rtl/prio_arb_tree.sv | 61 ++++++
 tb/tb_prio_arb_tree.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/prio_arb_tree.sv
// Registered N-input priority arbiter: a heap-ordered tree of 2:1 compare
// cells picks the requester with the smallest priority value, lowest index on ties.
module prio_arb_tree #(
    parameter int N         = 8,
    parameter int PRIO_BITS = 3,
    localparam int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N-1:0]           req_i,
    input  logic [N*PRIO_BITS-1:0] prio_i,
    output logic                   req_o,
    output logic [SEL_W-1:0]       sel_o,
    output logic [PRIO_BITS-1:0]   prio_o
);
    localparam int LVLS  = (N > 1) ? $clog2(N) : 0;
    localparam int P     = 1 << LVLS;
    localparam int NODES = 2 * P - 1;

    // Node 0 is the root, nodes P-1..2P-2 are leaves; children of i are 2i+1 (a) and 2i+2 (b).
    logic [NODES-1:0]                nreq;
    logic [NODES-1:0][SEL_W-1:0]     nsel;
    logic [NODES-1:0][PRIO_BITS-1:0] nprio;

    for (genvar k = 0; k < P; k++) begin : g_leaf
        if (k < N) begin : g_real
            assign nreq[P-1+k]  = req_i[k];
            assign nprio[P-1+k] = prio_i[k*PRIO_BITS +: PRIO_BITS];
        end else begin : g_pad
            assign nreq[P-1+k]  = 1'b0;
            assign nprio[P-1+k] = '0;
        end
        assign nsel[P-1+k] = SEL_W'(k);
    end

    for (genvar i = 0; i < P - 1; i++) begin : g_cell
        logic pick_b;
        assign pick_b   = nreq[2*i+2] & (~nreq[2*i+1] | (nprio[2*i+2] < nprio[2*i+1]));
        assign nreq[i]  = nreq[2*i+1] | nreq[2*i+2];
        assign nsel[i]  = pick_b ? nsel[2*i+2]  : nsel[2*i+1];
        assign nprio[i] = pick_b ? nprio[2*i+2] : nprio[2*i+1];
    end

    // Idle cycles report zero rather than whatever leaf 0 happens to carry.
    logic [SEL_W-1:0]     root_sel;
    logic [PRIO_BITS-1:0] root_prio;
    assign root_sel  = nreq[0] ? nsel[0]  : '0;
    assign root_prio = nreq[0] ? nprio[0] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_o  <= 1'b0;
            sel_o  <= '0;
            prio_o <= '0;
        end else begin
            req_o  <= nreq[0];
            sel_o  <= root_sel;
            prio_o <= root_prio;
        end
    end
endmodule

// File: tb/tb_prio_arb_tree.sv
// Bench for prio_arb_tree: N=8, N=5 and N=2 instances checked every cycle
// against a min-search reference, plus directed literal cases and async reset.
module tb_prio_arb_tree;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  req8 = '0;
    logic [23:0] prio8 = '0;
    logic        r8;
    logic [2:0]  s8, p8;

    logic [4:0]  req5 = '0;
    logic [14:0] prio5 = '0;
    logic        r5;
    logic [2:0]  s5, p5;

    logic [1:0]  req2 = '0;
    logic [5:0]  prio2 = '0;
    logic        r2;
    logic [0:0]  s2;
    logic [2:0]  p2;

    int checks = 0;
    int errors = 0;

    prio_arb_tree #(.N(8), .PRIO_BITS(3)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req8), .prio_i(prio8),
        .req_o(r8), .sel_o(s8), .prio_o(p8));
    prio_arb_tree #(.N(5), .PRIO_BITS(3)) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req5), .prio_i(prio5),
        .req_o(r5), .sel_o(s5), .prio_o(p5));
    prio_arb_tree #(.N(2), .PRIO_BITS(3)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .prio_i(prio2),
        .req_o(r2), .sel_o(s2), .prio_o(p2));

    // Result packed as {req, sel[3:0], prio[2:0]}: scan requesters for the strict minimum.
    function automatic logic [7:0] model(input int n, input logic [7:0] req, input logic [23:0] prio);
        logic       found = 1'b0;
        logic [3:0] bsel = '0;
        logic [2:0] bprio = '0;
        for (int k = 0; k < n; k++) begin
            if (req[k] && (!found || prio[k*3 +: 3] < bprio)) begin
                found = 1'b1;
                bsel  = 4'(k);
                bprio = prio[k*3 +: 3];
            end
        end
        return {found, bsel, bprio};
    endfunction

    function automatic logic [7:0] got8(); return {r8, 1'b0, s8, p8}; endfunction
    function automatic logic [7:0] got5(); return {r5, 1'b0, s5, p5}; endfunction
    function automatic logic [7:0] got2(); return {r2, 3'b000, s2, p2}; endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got req=%0b sel=%0d prio=%0d want req=%0b sel=%0d prio=%0d @%0t",
                     name, got[7], got[6:3], got[2:0], want[7], want[6:3], want[2:0], $time);
        end
    endtask

    logic [7:0] exp8 = '0, exp5 = '0, exp2 = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp8 <= '0; exp5 <= '0; exp2 <= '0;
        end else begin
            exp8 <= model(8, req8, prio8);
            exp5 <= model(5, {3'b0, req5}, {9'b0, prio5});
            exp2 <= model(2, {6'b0, req2}, {18'b0, prio2});
        end
    end

    always @(negedge clk) begin
        chk("cyc_n8", got8(), exp8);
        chk("cyc_n5", got5(), exp5);
        chk("cyc_n2", got2(), exp2);
    end

    task automatic setup_next();
        @(negedge clk);
        #2;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Pin the reference with hand-computed cases.
        chk("model_basic", model(8, 8'b11011011, 24'o12340567), {1'b1, 4'd3, 3'd0});
        chk("model_tie",   model(8, 8'b10100100, 24'o55555555), {1'b1, 4'd2, 3'd5});
        chk("model_mask",  model(8, 8'b01000000, 24'o37333303), {1'b1, 4'd6, 3'd7});

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_n8", got8(), 8'h00);
        chk("reset_n5", got5(), 8'h00);
        setup_next();
        rst_n = 1'b1;

        setup_next();
        prio8 = 24'o12340567; req8 = 8'b11011011;
        req2 = 2'b11; prio2 = {3'd1, 3'd6};
        after_edge();
        chk("basic", got8(), {1'b1, 4'd3, 3'd0});
        chk("cell_b_wins", got2(), {1'b1, 3'b0, 1'b1, 3'd1});

        setup_next();
        req8 = 8'b00000000;
        prio2 = {3'd6, 3'd1};
        after_edge();
        chk("idle", got8(), 8'h00);
        chk("cell_swap", got2(), {1'b1, 3'b0, 1'b0, 3'd1});

        setup_next();
        prio8 = 24'o55555555; req8 = 8'b10100100;
        prio2 = {3'd4, 3'd4};
        after_edge();
        chk("tie_low_idx", got8(), {1'b1, 4'd2, 3'd5});
        chk("cell_equal", got2(), {1'b1, 3'b0, 1'b0, 3'd4});

        setup_next();
        req8 = 8'hff;
        after_edge();
        chk("all_equal", got8(), {1'b1, 4'd0, 3'd5});

        setup_next();
        prio8 = 24'o37333303; req8 = 8'b01000000;
        req5 = 5'b10000; prio5 = 15'o73210;
        after_edge();
        chk("mask", got8(), {1'b1, 4'd6, 3'd7});
        chk("n5_top", got5(), {1'b1, 4'd4, 3'd7});

        // Reset pulse between edges while a winner is held.
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_n8", got8(), 8'h00);
        chk("midreset_n5", got5(), 8'h00);
        rst_n = 1'b1;
        after_edge();
        chk("restore_n8", got8(), {1'b1, 4'd6, 3'd7});
        chk("restore_n5", got5(), {1'b1, 4'd4, 3'd7});

        // Randomized traffic; small priority ranges make ties common.
        for (int c = 0; c < 3000; c++) begin
            setup_next();
            req8  = 8'($urandom) & (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hff);
            req5  = 5'($urandom);
            req2  = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) prio8[k*3 +: 3] = 3'($urandom_range(0, 2));
                for (int k = 0; k < 5; k++) prio5[k*3 +: 3] = 3'($urandom_range(0, 2));
            end else begin
                prio8 = 24'($urandom);
                prio5 = 15'($urandom);
            end
            prio2 = 6'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        setup_next();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
